// File: rtl/mdr_buf.sv
// mdr_buf: two independent FIFOs bridging an external bus (eb) and an internal bus (ib).
// Define MDR_BUF_ERR_EN to build the sticky overflow/underflow flags on err.

module mdr_buf_q #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign head    = mem[rptr];

    // Storage carries no reset; its contents are unobservable while the queue is empty.
    always_ff @(posedge clk)
        if (reset && do_push) mem[wptr] <= data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module mdr_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io,
    input  logic             w,
    input  logic             rd,
    inout  wire  [WIDTH-1:0] eb,
    inout  wire  [WIDTH-1:0] ib,
    output logic             in_empty,
    output logic             in_full,
    output logic             out_empty,
    output logic             out_full,
    output logic [1:0]       err
);
    // Index 1 = inbound (eb -> ib), index 0 = outbound (ib -> eb).
    logic [1:0][WIDTH-1:0] data, head;
    logic [1:0]            push, pop, empty, full;

    assign data[1] = eb;
    assign data[0] = ib;

    for (genvar g = 0; g < 2; g++) begin : g_q
        assign push[g] = w && (io == 1'(g));
        assign pop[g]  = rd && !w && (io == 1'(g));

        mdr_buf_q #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_q (
            .clk   (clk),
            .reset (reset),
            .push  (push[g]),
            .pop   (pop[g]),
            .data  (data[g]),
            .head  (head[g]),
            .empty (empty[g]),
            .full  (full[g])
        );
    end

    assign in_empty  = empty[1];
    assign in_full   = full[1];
    assign out_empty = empty[0];
    assign out_full  = full[0];

    assign ib = (!w && io  && !empty[1]) ? head[1] : 'z;
    assign eb = (!w && !io && !empty[0]) ? head[0] : 'z;

`ifdef MDR_BUF_ERR_EN
    logic [1:0] err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 2'b00;
        end else begin
            if (|(push & full))  err_q[1] <= 1'b1;
            if (|(pop & empty))  err_q[0] <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 2'b00;
`endif
endmodule

// File: tb/tb_mdr_buf.sv
// Scoreboard bench for mdr_buf: stimulus queues expectations, a monitor pops and compares.
// An undriven bus is detected by the bench driving 0 onto it and expecting 0 back.
module tb_mdr_buf;
`ifdef MDR_BUF_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif
    localparam int SEL_IB = 0, SEL_EB = 1, SEL_FLG = 2, SEL_ERR = 3, SEL_IB16 = 4, SEL_FLG16 = 5;

    logic clk, reset, io, w, rd, io16, w16, rd16;
    logic in_empty, in_full, out_empty, out_full;
    logic in_empty16, in_full16, out_empty16, out_full16;
    logic [1:0] err, err16;
    logic eb_en, ib_en, eb16_en, ib16_en;
    logic [7:0] eb_drv, ib_drv;
    logic [15:0] eb16_drv, ib16_drv;
    wire [7:0] eb, ib;
    wire [15:0] eb16, ib16;

    assign eb   = eb_en   ? eb_drv   : 'z;
    assign ib   = ib_en   ? ib_drv   : 'z;
    assign eb16 = eb16_en ? eb16_drv : 'z;
    assign ib16 = ib16_en ? ib16_drv : 'z;

    mdr_buf #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .io(io), .w(w), .rd(rd), .eb(eb), .ib(ib),
        .in_empty(in_empty), .in_full(in_full), .out_empty(out_empty),
        .out_full(out_full), .err(err));

    mdr_buf #(.WIDTH(16), .DEPTH(4)) dut16 (
        .clk(clk), .reset(reset), .io(io16), .w(w16), .rd(rd16), .eb(eb16), .ib(ib16),
        .in_empty(in_empty16), .in_full(in_full16), .out_empty(out_empty16),
        .out_full(out_full16), .err(err16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } rec_t;

    rec_t sb[$];
    rec_t e;
    logic [15:0] act;
    int n_cmp = 0;
    int n_bad = 0;
    event kick;

    // Monitor: drains the scoreboard on every falling edge, or on demand between edges.
    always begin
        @(negedge clk or kick);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_IB:    act = {8'h00, ib};
                SEL_EB:    act = {8'h00, eb};
                SEL_FLG:   act = {12'h000, in_empty, in_full, out_empty, out_full};
                SEL_ERR:   act = {14'h0000, err};
                SEL_IB16:  act = ib16;
                default:   act = {12'h000, in_empty16, in_full16, out_empty16, out_full16};
            endcase
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic chk(input string name, input int sel, input logic [15:0] exp);
        rec_t r;
        r.name = name;
        r.sel  = sel;
        r.exp  = exp;
        sb.push_back(r);
    endtask

    task automatic probe_ib(input string name);
        ib_en  = 1'b1;
        ib_drv = 8'h00;
        chk(name, SEL_IB, 16'h0000);
    endtask

    task automatic push_in(input logic [7:0] v);
        @(negedge clk); #1;
        io = 1'b1; w = 1'b1; rd = 1'b0; ib_en = 1'b0; eb_en = 1'b1; eb_drv = v;
        @(posedge clk); #1;
        w = 1'b0; eb_en = 1'b0;
    endtask

    task automatic push_out(input logic [7:0] v);
        @(negedge clk); #1;
        io = 1'b0; w = 1'b1; rd = 1'b0; eb_en = 1'b0; ib_en = 1'b1; ib_drv = v;
        @(posedge clk); #1;
        w = 1'b0; ib_en = 1'b0;
    endtask

    task automatic pop(input logic dir);
        @(negedge clk); #1;
        io = dir; w = 1'b0; rd = 1'b1; eb_en = 1'b0; ib_en = 1'b0;
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; io = 1'b1; w = 1'b0; rd = 1'b0;
        io16 = 1'b1; w16 = 1'b0; rd16 = 1'b0;
        eb_en = 1'b0; ib_en = 1'b0; eb16_en = 1'b0; ib16_en = 1'b0;
        eb_drv = '0; ib_drv = '0; eb16_drv = '0; ib16_drv = '0;

        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL d_rst_in_empty: got %b expected 1", in_empty);
        end
        chk("rst_flags", SEL_FLG, 16'h000A);
        chk("rst_err", SEL_ERR, 16'h0000);
        chk("rst_flags16", SEL_FLG16, 16'h000A);
        probe_ib("rst_ib_z");
        @(negedge clk); #1;
        ib_en = 1'b0;
        reset = 1'b1;

        // Inbound single word
        push_in(8'h33);
        #1;
        n_cmp++;
        if (ib !== 8'h33) begin
            n_bad++;
            $display("FAIL d_in_ib: got %h expected 33", ib);
        end
        chk("in_ib", SEL_IB, 16'h0033);
        chk("in_flags", SEL_FLG, 16'h0002);
        pop(1'b1);
        probe_ib("in_pop_ib_z");
        chk("in_pop_flags", SEL_FLG, 16'h000A);

        // Outbound single word
        push_out(8'h11);
        chk("out_eb", SEL_EB, 16'h0011);
        chk("out_flags", SEL_FLG, 16'h0008);
        pop(1'b0);
        chk("out_pop_flags", SEL_FLG, 16'h000A);

        // Overflow: fifth push is dropped
        for (int k = 1; k <= 4; k++) push_in(8'(k));
        n_cmp++;
        if (in_full !== 1'b1) begin
            n_bad++;
            $display("FAIL d_ovf_full: got %b expected 1", in_full);
        end
        chk("ovf_full", SEL_FLG, 16'h0006);
        push_in(8'h05);
        chk("ovf_flags", SEL_FLG, 16'h0006);
        chk("ovf_err", SEL_ERR, {14'h0, ERR_EN, 1'b0});
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_order", SEL_IB, 16'(k));
            pop(1'b1);
        end
        chk("ovf_drained", SEL_FLG, 16'h000A);
        probe_ib("ovf_ib_z");

        // Underflow on outbound, then wrap-around traffic
        pop(1'b0);
        chk("udf_flags", SEL_FLG, 16'h000A);
        chk("udf_err", SEL_ERR, {14'h0, ERR_EN, ERR_EN});
        for (int k = 0; k < 6; k++) begin
            push_out(8'h21 + 8'(k));
            chk("wrap_pair", SEL_EB, 16'h0021 + 16'(k));
            pop(1'b0);
        end
        push_out(8'h31);
        push_out(8'h32);
        push_out(8'h33);
        for (int k = 0; k < 3; k++) begin
            chk("wrap_order", SEL_EB, 16'h0031 + 16'(k));
            pop(1'b0);
        end
        chk("wrap_empty", SEL_FLG, 16'h000A);

        // Reset asserted between edges with entries queued
        push_in(8'h41);
        push_in(8'h42);
        push_in(8'h43);
        chk("mid_ib", SEL_IB, 16'h0041);
        chk("mid_flags", SEL_FLG, 16'h0002);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL d_mid_in_empty: got %b expected 1", in_empty);
        end
        probe_ib("mid_rst_ib_z");
        chk("mid_rst_flags", SEL_FLG, 16'h000A);
        chk("mid_rst_err", SEL_ERR, 16'h0000);
        -> kick;
        #1;
        ib_en = 1'b0;
        // A push attempted while reset is held must not land
        io = 1'b1; w = 1'b1; eb_en = 1'b1; eb_drv = 8'h77;
        @(posedge clk); #1;
        w = 1'b0; eb_en = 1'b0;
        reset = 1'b1;
        chk("rst_hold_flags", SEL_FLG, 16'h000A);
        probe_ib("rst_hold_ib_z");

        // 16-bit instance
        @(negedge clk); #1;
        ib_en = 1'b0;
        io16 = 1'b1; w16 = 1'b1; eb16_en = 1'b1; eb16_drv = 16'hA5C3;
        @(posedge clk); #1;
        w16 = 1'b0; eb16_en = 1'b0;
        #1;
        n_cmp++;
        if (ib16 !== 16'hA5C3) begin
            n_bad++;
            $display("FAIL d_w16_ib: got %h expected a5c3", ib16);
        end
        chk("w16_ib", SEL_IB16, 16'hA5C3);
        chk("w16_flags", SEL_FLG16, 16'h0002);

        @(negedge clk); #1;
        if (n_cmp == 0) begin
            n_bad++;
            $display("FAIL no_checks: got 0 comparisons expected >0");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mdr_buf.md
MDR_BUF -- requirements
Module: mdr_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bus width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, entries per direction queue (power of 2, >=2).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL have port io, input, 1, direction select.
- 1 = external-to-internal (inbound) queue.
- 0 = internal-to-external (outbound) queue.
REQ-006 SHALL have port w, input, 1, write strobe; pushes into the queue selected by io.
REQ-007 SHALL have port rd, input, 1, pop strobe; pops the queue selected by io.
REQ-008 SHALL have port eb, inout, WIDTH, external bus.
REQ-009 SHALL have port ib, inout, WIDTH, internal bus.
REQ-010 SHALL have ports in_empty, in_full, out_empty, out_full, output, 1 each, queue status flags.
REQ-011 SHALL have port err, output, 2, sticky error flags: bit1 = overflow, bit0 = underflow.

Function
REQ-012 SHALL push eb into the inbound queue on a clk edge with w=1, io=1 and in_full=0.
REQ-013 SHALL push ib into the outbound queue on a clk edge with w=1, io=0 and out_full=0.
REQ-014 SHALL drive ib with the inbound head when w=0, io=1 and in_empty=0; otherwise ib SHALL be high-Z.
REQ-015 SHALL drive eb with the outbound head when w=0, io=0 and out_empty=0; otherwise eb SHALL be high-Z.
REQ-016 SHALL never drive eb or ib while w=1.
REQ-017 SHALL remove the head of the io-selected queue on a clk edge with rd=1, w=0 and that queue non-empty.
REQ-018 SHALL ignore rd while w=1: no pop, no error.
REQ-019 SHALL apply push and pop latency as follows.
- A word pushed into an empty queue is driven from the cycle after the push edge.
- Its empty flag deasserts that same cycle.
REQ-020 SHALL apply the same cycle timing to full/empty flag updates: they change the cycle after the causing edge.
REQ-021 SHALL drop a push into a full queue; contents are unchanged and err[1] is set.
REQ-022 SHALL ignore a pop from an empty queue and set err[0].
REQ-023 SHALL keep inbound and outbound queues independent; operating one never changes the other.
REQ-024 SHALL wrap read/write pointers modulo DEPTH and track occupancy 0..DEPTH exactly.
- Full means count = DEPTH.
- Empty means count = 0.
REQ-025 SHALL preserve FIFO order per queue across pointer wrap-around.
REQ-026 SHALL hold err bits once set until reset.

Reset
REQ-027 SHALL, on reset=0 at any time including mid-operation, immediately take the following values.
- Both queues empty (pointers and counts 0).
- in_empty=1, out_empty=1, in_full=0, out_full=0, err=2'b00.
- eb and ib high-Z.
REQ-028 SHALL perform no push or pop while reset=0; operation resumes on the first clk edge after reset=1.
REQ-029 SHALL leave queue storage contents undefined after reset; they are unobservable.

Configuration
REQ-030 SHALL compile the error logic in only when the macro MDR_BUF_ERR_EN is defined.
- Defined: err behaves per REQ-021, REQ-022 and REQ-026.
- Undefined: err is constant 2'b00 and no error registers exist; all other behaviour is identical.

Verification
REQ-031 SHALL cover inbound: reset, then eb=8'h33 with w=1, io=1 for one edge, then w=0, io=1 -> ib=8'h33 next cycle, in_empty=0; then rd=1 for one edge -> ib=Z, in_empty=1.
REQ-032 SHALL cover outbound: ib=8'h11 with w=1, io=0 for one edge, then w=0, io=0 -> eb=8'h11, out_empty=0, inbound queue unaffected.
REQ-033 SHALL cover overflow: push 8'h01..8'h05 inbound (DEPTH=4) -> in_full=1 after the 4th push; 8'h05 dropped; err[1]=1 with MDR_BUF_ERR_EN; pops return 01,02,03,04.
REQ-034 SHALL cover underflow and wrap: pop an empty outbound queue -> err[0]=1 and flags unchanged; then 6 interleaved push/pop pairs -> data returned in order across wrap.
REQ-035 SHALL cover reset mid-operation: 3 inbound entries, reset=0 asserted between edges -> in_empty=1 and ib=Z immediately, err=0.
REQ-036 SHALL cover width: WIDTH=16 instance, push 16'hA5C3 via eb -> ib=16'hA5C3.
